// File: rtl/mem_arbiter.sv
// mem_arbiter: three-port arbiter for the shared game memory port.
//   port 0 = graphic controller, port 1 = game processor, port 2 = second processor.
// Each port may queue one access; winners are picked round-robin and served
// with a single fixed-latency access on the memory-controller interface.
// Build option: define MEM_ARB_GPU_PRIORITY_EN to let a pending port 0 win
// unconditionally, with ports 1 and 2 round-robining between themselves.
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = 2    // legal range 1..15
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [2:0]          REQ,
  input  logic [2:0]          WRITE,
  input  logic [3*ADDR_W-1:0] ADDR,
  input  logic [3*DATA_W-1:0] WDATA,
  output logic [2:0]          BUSY,
  output logic [2:0]          GNT,
  output logic [2:0]          DONE,
  output logic [3*DATA_W-1:0] RDATA,
  output logic                MEM_ENABLE,
  output logic                MEM_WRITE,
  output logic [ADDR_W-1:0]   MEM_ADDR,
  output logic [DATA_W-1:0]   MEM_DATA_W,
  input  logic [DATA_W-1:0]   MEM_DATA_R
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

`ifdef MEM_ARB_GPU_PRIORITY_EN
  localparam bit GPU_PRIORITY = 1'b1;
`else
  localparam bit GPU_PRIORITY = 1'b0;
`endif
  localparam logic [3:0] LATENCY = 4'(MEM_LATENCY);

  state_t              state, state_next;
  logic [2:0]          pending;
  logic [1:0]          last_gnt;    // port granted most recently
  logic [1:0]          winner;      // port currently in service
  logic [1:0]          pick;
  logic                found;
  logic [2:0]          candidates;
  logic [2:0]          in_service;
  logic [2:0]          accept;
  logic [2:0]          take;
  logic [3:0]          cnt;
  logic                lat_write;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;

  // Ports eligible this round; with GPU priority a pending port 0 masks the rest.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    candidates = pending;
    if (GPU_PRIORITY && pending[0]) candidates = 3'b001;
  end

  // Circular search starting at the port after the last granted one.
  always_comb begin
    logic [1:0] idx;
    pick  = 2'd0;
    found = 1'b0;
    idx   = last_gnt;
    for (int i = 0; i < 3; i++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (!found && candidates[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Request acceptance, grant take-over and per-port busy view.
  always_comb begin
    in_service = (state != S_IDLE) ? (3'b001 << winner) : 3'b000;
    BUSY       = pending | in_service;
    accept     = REQ & ~BUSY;
    take       = (state == S_IDLE && found) ? (3'b001 << pick) : 3'b000;
  end

  // Next-state and strobe outputs of the access sequencer.
  always_comb begin
    state_next = state;
    GNT        = 3'b000;
    DONE       = 3'b000;
    MEM_ENABLE = 1'b0;
    case (state)
      S_IDLE:  if (found) state_next = S_ISSUE;
      S_ISSUE: begin
        MEM_ENABLE = 1'b1;
        GNT        = 3'b001 << winner;
        state_next = S_WAIT;
      end
      S_WAIT:  if (cnt == 4'd1) state_next = S_DONE;
      S_DONE:  begin
        DONE       = 3'b001 << winner;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  // Pending bits, grant latching, latency countdown and read-data return.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pending   <= 3'b000;
      last_gnt  <= 2'd2;          // priority order 0,1,2 after reset
      winner    <= 2'd0;
      cnt       <= 4'd0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      // NOTE: the read-data bank is cleared on reset because ports see it directly.
      RDATA     <= '0;
    end else begin
      pending <= (pending | accept) & ~take;
      if (take != 3'b000) begin
        winner    <= pick;
        lat_write <= WRITE[pick];
        lat_addr  <= ADDR[pick*ADDR_W +: ADDR_W];
        lat_wdata <= WDATA[pick*DATA_W +: DATA_W];
        if (!(GPU_PRIORITY && pick == 2'd0)) last_gnt <= pick;
      end
      if (state == S_ISSUE) begin
        cnt <= LATENCY;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1 && !lat_write) RDATA[winner*DATA_W +: DATA_W] <= MEM_DATA_R;
      end
    end
  end

  // Address/data hold the latched grant values through the whole access.
  assign MEM_WRITE  = lat_write;
  assign MEM_ADDR   = lat_addr;
  assign MEM_DATA_W = lat_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-timeline model (grant cycle g, done cycle g+L+1).
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int L  = 2;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [2:0]        REQ;
  logic [2:0]        WRITE;
  logic [3*AW-1:0]   ADDR;
  logic [3*DW-1:0]   WDATA;
  logic [2:0]        BUSY;
  logic [2:0]        GNT;
  logic [2:0]        DONE;
  logic [3*DW-1:0]   RDATA;
  logic              MEM_ENABLE;
  logic              MEM_WRITE;
  logic [AW-1:0]     MEM_ADDR;
  logic [DW-1:0]     MEM_DATA_W;
  logic [DW-1:0]     MEM_DATA_R;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(L)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .WRITE(WRITE), .ADDR(ADDR), .WDATA(WDATA),
    .BUSY(BUSY), .GNT(GNT), .DONE(DONE), .RDATA(RDATA),
    .MEM_ENABLE(MEM_ENABLE), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
    .MEM_DATA_W(MEM_DATA_W), .MEM_DATA_R(MEM_DATA_R)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en   = 1'b0;
  bit mem_rand = 1'b0;
  logic [DW-1:0] mem_fixed = 16'hBEEF;

  // Reference model: pending set, the access in service and when it was granted.
  logic [2:0]    pend = 3'b000;
  int            svc  = -1;
  int            g    = 0;
  int            last = 2;
  logic          s_write;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] m_rdata [3];

  int gnt_log[$];
  int en_cnt = 0;
  int done_cnt [3] = '{default: 0};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic int pick(input logic [2:0] p, input int lst);
    logic [1:0] k;
`ifdef MEM_ARB_GPU_PRIORITY_EN
    if (p[0]) return 0;
`endif
    for (int i = 1; i <= 3; i++) begin
      k = 2'((lst + i) % 3);
      if (p[k]) return int'(k);
    end
    return -1;
  endfunction

  // Memory read data: fixed for directed tests, random otherwise.
  always @(posedge CLK) begin
    #1;
    MEM_DATA_R = mem_rand ? 16'($urandom) : mem_fixed;
  end

  // Model update at each edge from the inputs held during the previous cycle.
  always @(posedge CLK) begin : model
    logic [2:0] busy_prev;
    bit         idle_prev;
    int         w;
    cyc++;
    if (RESET) begin
      pend = 3'b000;
      svc  = -1;
      last = 2;
      for (int n = 0; n < 3; n++) m_rdata[n] = '0;
    end else begin
      busy_prev = pend | ((svc >= 0) ? 3'(1 << svc) : 3'b000);
      idle_prev = (svc < 0);
      if (svc >= 0 && cyc == g + L + 1 && !s_write) m_rdata[svc] = MEM_DATA_R;
      if (svc >= 0 && cyc == g + L + 2) svc = -1;
      if (idle_prev && pend != 3'b000) begin
        w       = pick(pend, last);
        svc     = w;
        g       = cyc;
        s_write = WRITE[w];
        s_addr  = ADDR[w*AW +: AW];
        s_wdata = WDATA[w*DW +: DW];
        pend[w] = 1'b0;
`ifdef MEM_ARB_GPU_PRIORITY_EN
        if (w != 0) last = w;
`else
        last = w;
`endif
      end
      pend = pend | (REQ & ~busy_prev);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CLK) begin : compare
    logic [2:0] oh;
    logic in_g, in_d, in_w;
    if (chk_en) begin
      oh   = (svc >= 0) ? 3'(1 << svc) : 3'b000;
      in_g = (svc >= 0) && (cyc == g);
      in_d = (svc >= 0) && (cyc == g + L + 1);
      in_w = (svc >= 0) && (cyc >= g) && (cyc <= g + L);
      check("gnt", GNT, in_g ? oh : 3'b000);
      check("mem_enable", MEM_ENABLE, in_g);
      check("done", DONE, in_d ? oh : 3'b000);
      check("busy", BUSY, pend | oh);
      check("rdata", RDATA, {m_rdata[2], m_rdata[1], m_rdata[0]});
      if (in_w) begin
        check("mem_write", MEM_WRITE, s_write);
        check("mem_addr", MEM_ADDR, s_addr);
        check("mem_data_w", MEM_DATA_W, s_wdata);
      end
      if (GNT == 3'b001) gnt_log.push_back(0);
      else if (GNT == 3'b010) gnt_log.push_back(1);
      else if (GNT == 3'b100) gnt_log.push_back(2);
      if (MEM_ENABLE) en_cnt++;
      for (int n = 0; n < 3; n++) if (DONE[n]) done_cnt[n]++;
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (BUSY !== 3'b000 && k < 200) begin
      step();
      k++;
    end
    check("idle_reached", {63'd0, BUSY === 3'b000}, 64'd1);
  endtask

  task automatic wait_done0();
    int k;
    k = 0;
    while (DONE[0] !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    check("done0_seen", {63'd0, DONE[0] === 1'b1}, 64'd1);
  endtask

  task automatic check_log(input string nm, input int base, input int n,
                           input int e0, input int e1, input int e2, input int e3);
    int e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    check({nm, "_count"}, gnt_log.size() - base, n);
    for (int i = 0; i < n; i++)
      if (base + i < gnt_log.size()) check({nm, "_order"}, gnt_log[base+i], e[i]);
  endtask

  initial begin
    int base, en0, d0, d1;
    logic [2:0] r;
    logic mb;
    RESET = 1'b1; REQ = '0; WRITE = '0; ADDR = '0; WDATA = '0;
    step();
    step();
    chk_en = 1'b1;
    check("rst_busy", BUSY, 0);
    check("rst_gnt", GNT, 0);
    check("rst_done", DONE, 0);
    check("rst_rdata", RDATA, 0);
    check("rst_mem_en", MEM_ENABLE, 0);
    check("rst_mem_write", MEM_WRITE, 0);
    check("rst_mem_addr", MEM_ADDR, 0);
    check("rst_mem_wdata", MEM_DATA_W, 0);
    RESET = 1'b0;
    step();

    // Single read from port 1.
    ADDR[AW +: AW] = 16'h0040; WRITE[1] = 1'b0; REQ = 3'b010;
    step(); REQ = '0;
    check("rd_pending", BUSY, 3'b010);
    check("rd_no_gnt_yet", GNT, 0);
    step();
    check("rd_gnt", GNT, 3'b010);
    check("rd_mem_en", MEM_ENABLE, 1);
    check("rd_mem_addr", MEM_ADDR, 16'h0040);
    check("rd_mem_write", MEM_WRITE, 0);
    step(); step();
    check("rd_no_done_early", DONE, 0);
    step();
    check("rd_done", DONE, 3'b010);
    check("rd_busy_in_done", BUSY, 3'b010);
    step();
    check("rd_rdata", RDATA[DW +: DW], 16'hBEEF);
    check("rd_busy_drop", BUSY, 0);

    // Write from port 2.
    WRITE[2] = 1'b1; ADDR[2*AW +: AW] = 16'h0100; WDATA[2*DW +: DW] = 16'h1234; REQ = 3'b100;
    step(); REQ = '0;
    step();
    check("wr_gnt", GNT, 3'b100);
    check("wr_mem_en", MEM_ENABLE, 1);
    check("wr_mem_write", MEM_WRITE, 1);
    check("wr_mem_addr", MEM_ADDR, 16'h0100);
    check("wr_mem_wdata", MEM_DATA_W, 16'h1234);
    step(); step(); step();
    check("wr_done", DONE, 3'b100);
    step();
    check("wr_rdata_kept", RDATA[2*DW +: DW], 16'h0000);

    // Round-robin order.
    WRITE = 3'b000;
    base = gnt_log.size();
    REQ = 3'b111; step(); REQ = '0; wait_idle();
    check_log("rr_first", base, 3, 0, 1, 2, 0);
    base = gnt_log.size();
    REQ = 3'b111; step(); REQ = '0; wait_idle();
    check_log("rr_second", base, 3, 0, 1, 2, 0);
    base = gnt_log.size();
    REQ = 3'b010; step(); REQ = '0; wait_idle();
    REQ = 3'b011; step(); REQ = '0; wait_idle();
    check_log("rr_after_1", base, 3, 1, 0, 1, 0);

    // Second REQ while busy is dropped.
    en0 = en_cnt; d0 = done_cnt[0];
    REQ = 3'b001; step(); REQ = '0; step();
    REQ = 3'b001; step(); REQ = '0;
    wait_idle();
    check("busy_drop_accesses", en_cnt - en0, 1);
    check("busy_drop_done0", done_cnt[0] - d0, 1);

    // Reset during WAIT of a port 1 read.
    mem_fixed = 16'h5A5A; WRITE[1] = 1'b0;
    step();
    REQ = 3'b010; step(); REQ = '0;
    step(); step();
    RESET = 1'b1;
    step();
    check("rw_busy", BUSY, 0);
    check("rw_mem_en", MEM_ENABLE, 0);
    check("rw_gnt", GNT, 0);
    check("rw_done", DONE, 0);
    check("rw_rdata1", RDATA[DW +: DW], 16'h0000);
    RESET = 1'b0;
    en0 = en_cnt; d1 = done_cnt[1];
    repeat (6) step();
    check("rw_no_reissue", en_cnt - en0, 0);
    check("rw_no_done", done_cnt[1] - d1, 0);

    // Port 0 re-requests after its DONE while ports 1 and 2 wait.
    base = gnt_log.size();
    REQ = 3'b111; step(); REQ = '0;
    wait_done0();
    step();
    REQ = 3'b001; step(); REQ = '0;
    wait_idle();
`ifdef MEM_ARB_GPU_PRIORITY_EN
    check_log("prio", base, 4, 0, 1, 0, 2);
`else
    check_log("prio", base, 4, 0, 1, 2, 0);
`endif

    // Randomized traffic, including requests while busy and occasional resets.
    mem_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      r = 3'b000;
      RESET = 1'b0;
      for (int n = 0; n < 3; n++) begin
        mb = pend[n] || (svc == n);
        if ($urandom_range(0, 5) == 0) begin
          r[n] = 1'b1;
          if (!mb) begin
            ADDR[n*AW +: AW]  = 16'($urandom);
            WDATA[n*DW +: DW] = 16'($urandom);
            WRITE[n]          = 1'($urandom_range(0, 1));
          end
        end
      end
      REQ = r;
      if ($urandom_range(0, 399) == 0) RESET = 1'b1;
      step();
    end
    REQ = '0; RESET = 1'b0;
    wait_idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
